// File: rtl/checkout_pkg.sv
// Shared types and UPC classification helpers for the checkout-lane controller.
package checkout_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        ALARM,
        DONE
    } state_t;

    localparam int unsigned UPC_M = 3;
    localparam int unsigned UPC_U = 2;
    localparam int unsigned UPC_P = 1;
    localparam int unsigned UPC_C = 0;

    function automatic logic is_stolen(input logic [3:0] upc);
        return (upc[UPC_U] & ~upc[UPC_P] & ~upc[UPC_M])
             | (~upc[UPC_M] & ~upc[UPC_U] & ~upc[UPC_C]);
    endfunction

    function automatic logic is_disc(input logic [3:0] upc);
        return (upc[UPC_M] & ~upc[UPC_U]) | (upc[UPC_P] & upc[UPC_C]);
    endfunction

endpackage

// File: rtl/checkout_ctrl_if.sv
// Scanner-to-controller handshake: valid/ready plus the scanned code and security mark.
interface checkout_ctrl_if;
    logic       scan_valid;
    logic       scan_ready;
    logic [3:0] upc;
    logic       mark;

    modport master (output scan_valid, output upc, output mark, input scan_ready);
    modport slave  (input scan_valid, input upc, input mark, output scan_ready);
endinterface

// File: rtl/checkout_ctrl_sat_counter.sv
// Saturating counter with synchronous load (priority) and increment.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/checkout_ctrl.sv
// Checkout-lane sequencer: accepts scanned codes, counts items/discounts per
// transaction, and raises a held theft alarm for unmarked theft-prone items.
module checkout_ctrl
    import checkout_pkg::*;
#(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned ALARM_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    checkout_ctrl_if.slave   scan,
    input  logic             checkout,
    input  logic             clear_alarm,
    output logic             alarm,
    output logic [3:0]       alarm_upc,
    output logic [CNT_W-1:0] item_count,
    output logic [CNT_W-1:0] disc_count,
    output logic             done
);

    localparam int unsigned         HOLD_W    = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]   HOLD_INIT = HOLD_W'(ALARM_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    logic [HOLD_W-1:0] hold;
    logic              ready;
    logic              accept;
    logic              trig;
    logic              item_disc;
    logic              cnt_load;
    logic              item_inc;
    logic              disc_inc;

    assign ready           = (state == IDLE) || (state == SCAN);
    assign scan.scan_ready = ready;
    assign accept          = scan.scan_valid & ready;
    assign trig            = accept & is_stolen(scan.upc) & ~scan.mark;
    assign item_disc       = is_disc(scan.upc);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A same-cycle alarm trigger outranks checkout, so the alarm test comes first.
    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        item_inc  = 1'b0;
        disc_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_load  = 1'b1;
                    state_nxt = trig ? ALARM : SCAN;
                end
            end
            SCAN: begin
                if (accept) begin
                    item_inc = 1'b1;
                    disc_inc = item_disc;
                end
                if (trig) begin
                    state_nxt = ALARM;
                end else if (checkout) begin
                    state_nxt = DONE;
                end
            end
            ALARM: begin
                if ((hold == '0) && clear_alarm) begin
                    state_nxt = SCAN;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alarm     <= 1'b0;
            alarm_upc <= '0;
            done      <= 1'b0;
            hold      <= '0;
        end else begin
            alarm <= (state_nxt == ALARM);
            done  <= (state_nxt == DONE);
            if (trig) begin
                alarm_upc <= scan.upc;
                hold      <= HOLD_INIT;
            end else if ((state == ALARM) && (hold != '0)) begin
                hold <= hold - HOLD_W'(1);
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_item_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (CNT_W'(1)),
        .inc      (item_inc),
        .count    (item_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_disc_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (CNT_W'(item_disc)),
        .inc      (disc_inc),
        .count    (disc_count)
    );

endmodule

// File: tb/tb_checkout_ctrl.sv
// Scoreboard bench for checkout_ctrl: dut_a (CNT_W=8, ALARM_CYCLES=4) and
// dut_b (CNT_W=2, ALARM_CYCLES=1) share clock and reset.
module tb_checkout_ctrl;

    localparam int S_IDLE  = 0;
    localparam int S_SCAN  = 1;
    localparam int S_ALARM = 2;
    localparam int S_DONE  = 3;

    typedef struct packed {
        logic       ready;
        logic       alarm;
        logic [3:0] aupc;
        logic [7:0] items;
        logic [7:0] disc;
        logic       done;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    checkout_ctrl_if bus_a ();
    checkout_ctrl_if bus_b ();

    logic       co_a, cl_a, alarm_a, done_a;
    logic [3:0] aupc_a;
    logic [7:0] items_a, disc_a;
    logic       co_b, cl_b, alarm_b, done_b;
    logic [3:0] aupc_b;
    logic [1:0] items_b, disc_b;

    checkout_ctrl #(.CNT_W(8), .ALARM_CYCLES(4)) dut_a (
        .clk(clk), .reset(reset), .scan(bus_a), .checkout(co_a), .clear_alarm(cl_a),
        .alarm(alarm_a), .alarm_upc(aupc_a), .item_count(items_a), .disc_count(disc_a), .done(done_a)
    );

    checkout_ctrl #(.CNT_W(2), .ALARM_CYCLES(1)) dut_b (
        .clk(clk), .reset(reset), .scan(bus_b), .checkout(co_b), .clear_alarm(cl_b),
        .alarm(alarm_b), .alarm_upc(aupc_b), .item_count(items_b), .disc_count(disc_b), .done(done_b)
    );

    int m_st[2], m_items[2], m_disc[2], m_hold[2], m_alarm[2], m_aupc[2], m_done[2];
    obs_t exp_q[$];
    obs_t obs_q[$];
    int compared   = 0;
    int mismatched = 0;

    // Truth tables of the classification (bit n = code n): stolen {0,2,4,5}, disc {3,7,8..11,15}.
    task automatic model_step(input int id, input logic rst, input logic v, input logic [3:0] u,
                              input logic mk, input logic co, input logic cl);
        logic [15:0] smap = 16'h0035;
        logic [15:0] dmap = 16'h8F88;
        int  maxv = (id == 0) ? 255 : 3;
        int  ac   = (id == 0) ? 4 : 1;
        bit  acc, trig, dsc;
        if (rst) begin
            m_st[id] = S_IDLE; m_items[id] = 0; m_disc[id] = 0;
            m_hold[id] = 0; m_alarm[id] = 0; m_aupc[id] = 0; m_done[id] = 0;
            return;
        end
        acc  = v && ((m_st[id] == S_IDLE) || (m_st[id] == S_SCAN));
        trig = acc && smap[u] && !mk;
        dsc  = dmap[u];
        case (m_st[id])
            S_IDLE: if (acc) begin
                m_items[id] = 1;
                m_disc[id]  = dsc ? 1 : 0;
                m_st[id]    = trig ? S_ALARM : S_SCAN;
            end
            S_SCAN: begin
                if (acc) begin
                    if (m_items[id] < maxv) m_items[id]++;
                    if (dsc && m_disc[id] < maxv) m_disc[id]++;
                end
                if (trig) m_st[id] = S_ALARM;
                else if (co) m_st[id] = S_DONE;
            end
            S_ALARM: begin
                if (m_hold[id] == 0 && cl) begin
                    m_st[id] = S_SCAN;
                    m_alarm[id] = 0;
                end else if (m_hold[id] > 0) begin
                    m_hold[id]--;
                end
            end
            default: m_st[id] = S_IDLE;
        endcase
        if (trig) begin
            m_alarm[id] = 1;
            m_aupc[id]  = int'(u);
            m_hold[id]  = ac - 1;
        end
        m_done[id] = (m_st[id] == S_DONE) ? 1 : 0;
    endtask

    function automatic obs_t expect_of(input int id);
        obs_t o;
        o.ready = (m_st[id] == S_IDLE) || (m_st[id] == S_SCAN);
        o.alarm = (m_alarm[id] != 0);
        o.aupc  = 4'(m_aupc[id]);
        o.items = 8'(m_items[id]);
        o.disc  = 8'(m_disc[id]);
        o.done  = (m_done[id] != 0);
        return o;
    endfunction

    function automatic obs_t observe(input int id);
        if (id == 0) return {bus_a.scan_ready, alarm_a, aupc_a, items_a, disc_a, done_a};
        return {bus_b.scan_ready, alarm_b, aupc_b, 6'b0, items_b, 6'b0, disc_b, done_b};
    endfunction

    task automatic drive(input int id, input logic rst, input logic v, input logic [3:0] u,
                         input logic mk, input logic co, input logic cl);
        reset = rst;
        bus_a.scan_valid = (id == 0) ? v : 1'b0;
        bus_a.upc = (id == 0) ? u : 4'h0;
        bus_a.mark = (id == 0) ? mk : 1'b0;
        co_a = (id == 0) ? co : 1'b0;
        cl_a = (id == 0) ? cl : 1'b0;
        bus_b.scan_valid = (id == 1) ? v : 1'b0;
        bus_b.upc = (id == 1) ? u : 4'h0;
        bus_b.mark = (id == 1) ? mk : 1'b0;
        co_b = (id == 1) ? co : 1'b0;
        cl_b = (id == 1) ? cl : 1'b0;
        model_step(0, rst, (id == 0) ? v : 1'b0, u, mk, (id == 0) ? co : 1'b0, (id == 0) ? cl : 1'b0);
        model_step(1, rst, (id == 1) ? v : 1'b0, u, mk, (id == 1) ? co : 1'b0, (id == 1) ? cl : 1'b0);
        exp_q.push_back(expect_of(id));
        @(posedge clk);
        #1;
        obs_q.push_back(observe(id));
    endtask

    task automatic test_reset();
        obs_t got, want;
        int k = 0;
        drive(0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        got = observe(0);
        compared++;
        if (got !== {1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_a: got %h required %h", got, {1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0});
        end
        while (exp_q.size() != 0) begin
            want = exp_q.pop_front(); got = obs_q.pop_front(); compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL reset[%0d]: got %h required %h", k, got, want);
            end
            k++;
        end
    endtask

    task automatic test_basic();
        obs_t got, want;
        int k = 0;
        drive(0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        got = observe(0);
        compared++;
        if (got.items !== 8'd3 || got.disc !== 8'd2 || got.done !== 1'b1 || got.alarm !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_done: items=%0d disc=%0d done=%b alarm=%b required 3 2 1 0",
                     got.items, got.disc, got.done, got.alarm);
        end
        drive(0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        got = observe(0);
        compared++;
        if (got.done !== 1'b0 || got.ready !== 1'b1 || got.items !== 8'd3) begin
            mismatched++;
            $display("FAIL basic_idle: done=%b ready=%b items=%0d required 0 1 3", got.done, got.ready, got.items);
        end
        while (exp_q.size() != 0) begin
            want = exp_q.pop_front(); got = obs_q.pop_front(); compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL basic[%0d]: got %h required %h", k, got, want);
            end
            k++;
        end
    endtask

    task automatic test_alarm();
        obs_t got, want;
        int k = 0;
        drive(0, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0);
        got = observe(0);
        compared++;
        if (got.alarm !== 1'b1 || got.aupc !== 4'b0100 || got.ready !== 1'b0 || got.items !== 8'd1) begin
            mismatched++;
            $display("FAIL alarm_raise: alarm=%b upc=%b ready=%b items=%0d required 1 0100 0 1",
                     got.alarm, got.aupc, got.ready, got.items);
        end
        drive(0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        got = observe(0);
        compared++;
        if (got.alarm !== 1'b1) begin
            mismatched++;
            $display("FAIL alarm_early_clear: alarm=%b required 1", got.alarm);
        end
        drive(0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        drive(0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        got = observe(0);
        compared++;
        if (got.alarm !== 1'b0 || got.ready !== 1'b1 || got.aupc !== 4'b0100 || got.done !== 1'b0) begin
            mismatched++;
            $display("FAIL alarm_clear: alarm=%b ready=%b upc=%b done=%b required 0 1 0100 0",
                     got.alarm, got.ready, got.aupc, got.done);
        end
        while (exp_q.size() != 0) begin
            want = exp_q.pop_front(); got = obs_q.pop_front(); compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL alarm[%0d]: got %h required %h", k, got, want);
            end
            k++;
        end
    endtask

    task automatic test_mark();
        obs_t got, want;
        int k = 0;
        drive(0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
        got = observe(0);
        compared++;
        if (got.alarm !== 1'b0 || got.items !== 8'd2) begin
            mismatched++;
            $display("FAIL mark_set: alarm=%b items=%0d required 0 2", got.alarm, got.items);
        end
        drive(0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        got = observe(0);
        compared++;
        if (got.alarm !== 1'b1 || got.aupc !== 4'b0000 || got.items !== 8'd3) begin
            mismatched++;
            $display("FAIL mark_clear: alarm=%b upc=%b items=%0d required 1 0000 3", got.alarm, got.aupc, got.items);
        end
        for (int i = 0; i < 3; i++) drive(0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        drive(0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        drive(0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            want = exp_q.pop_front(); got = obs_q.pop_front(); compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL mark[%0d]: got %h required %h", k, got, want);
            end
            k++;
        end
    endtask

    task automatic test_checkout_same_cycle();
        obs_t got, want;
        int k = 0;
        drive(0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b1, 4'b0011, 1'b0, 1'b1, 1'b0);
        got = observe(0);
        compared++;
        if (got.items !== 8'd2 || got.disc !== 8'd1 || got.done !== 1'b1) begin
            mismatched++;
            $display("FAIL co_item: items=%0d disc=%0d done=%b required 2 1 1", got.items, got.disc, got.done);
        end
        drive(0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b1, 1'b0);
        got = observe(0);
        compared++;
        if (got.alarm !== 1'b1 || got.done !== 1'b0 || got.items !== 8'd2) begin
            mismatched++;
            $display("FAIL co_alarm: alarm=%b done=%b items=%0d required 1 0 2", got.alarm, got.done, got.items);
        end
        drive(0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) drive(0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        drive(0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        drive(0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            want = exp_q.pop_front(); got = obs_q.pop_front(); compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL co_same[%0d]: got %h required %h", k, got, want);
            end
            k++;
        end
    endtask

    task automatic test_saturation();
        obs_t got, want;
        int k = 0;
        for (int i = 0; i < 5; i++) drive(1, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0);
        got = observe(1);
        compared++;
        if (got.items !== 8'd3 || got.disc !== 8'd3) begin
            mismatched++;
            $display("FAIL sat: items=%0d disc=%0d required 3 3", got.items, got.disc);
        end
        drive(1, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        got = observe(1);
        compared++;
        if (got.alarm !== 1'b0 || got.ready !== 1'b1 || got.aupc !== 4'b0010) begin
            mismatched++;
            $display("FAIL hold1_clear: alarm=%b ready=%b upc=%b required 0 1 0010", got.alarm, got.ready, got.aupc);
        end
        drive(1, 1'b1, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0);
        got = observe(1);
        compared++;
        if (got !== {1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_mid: got %h required %h", got, {1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0});
        end
        while (exp_q.size() != 0) begin
            want = exp_q.pop_front(); got = obs_q.pop_front(); compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL sat[%0d]: got %h required %h", k, got, want);
            end
            k++;
        end
    endtask

    task automatic test_random();
        obs_t got, want;
        int k = 0;
        for (int i = 0; i < 80; i++) begin
            drive(0, 1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));
        end
        while (exp_q.size() != 0) begin
            want = exp_q.pop_front(); got = obs_q.pop_front(); compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL random[%0d]: got %h required %h", k, got, want);
            end
            k++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_alarm();
        test_mark();
        test_checkout_same_cycle();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
